// File: rtl/branch_pkg.sv
// Shared types for the branch resolution unit.
// Holds condition codes, FSM states and stats width.
package branch_pkg;

  localparam int STAT_W = 16;

  typedef enum logic [2:0] {
    C_NONE   = 3'b000,
    C_EQ     = 3'b001,
    C_NE     = 3'b010,
    C_LT     = 3'b011,
    C_LE     = 3'b100,
    C_GT     = 3'b101,
    C_GE     = 3'b110,
    C_ALWAYS = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } br_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Maps a condition code and comparator flags to a take bit.
// Purely combinational; shared with the jump/compare fusion stage.
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic       eq_i,
  input  logic       neq_i,
  input  logic       lt_i,
  input  logic       lte_i,
  input  logic       gt_i,
  input  logic       gte_i,
  output logic       take_o
);

  always_comb begin
    take_o = 1'b0;
    unique case (cond_e'(cond_i))
      C_NONE:   take_o = 1'b0;
      C_EQ:     take_o = eq_i;
      C_NE:     take_o = neq_i;
      C_LT:     take_o = lt_i;
      C_LE:     take_o = lte_i;
      C_GT:     take_o = gt_i;
      C_GE:     take_o = gte_i;
      C_ALWAYS: take_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolve: take decision, target, redirect handshake, flush.
// Define BRANCH_STATS_EN to add saturating taken/not-taken counters.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int PC_W         = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      cond,
  input  logic            eq,
  input  logic            neq,
  input  logic            lt,
  input  logic            lte,
  input  logic            gt,
  input  logic            gte,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] offset,
  output logic            resolved,
  output logic            taken,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush
`ifdef BRANCH_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_not_taken
`endif
);

  localparam logic [3:0] CNT_LOAD =
    4'(FLUSH_CYCLES > 0 ? FLUSH_CYCLES - 1 : 0);

  br_state_e       state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            res_q, res_d;
  logic            tk_q, tk_d;
  logic [PC_W-1:0] tgt_q, tgt_d;
  logic            take;
  logic            accept;

  branch_cond_eval u_eval (
    .cond_i (cond),
    .eq_i   (eq),
    .neq_i  (neq),
    .lt_i   (lt),
    .lte_i  (lte),
    .gt_i   (gt),
    .gte_i  (gte),
    .take_o (take)
  );

  assign accept = in_valid && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = accept;
    tk_d    = accept && take;
    tgt_d   = accept ? pc + offset : tgt_q;
    unique case (state_q)
      IDLE: begin
        if (accept && take) state_d = REDIRECT;
      end
      REDIRECT: begin
        if (redirect_ready) begin
          if (FLUSH_CYCLES > 0) begin
            state_d = FLUSH;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else cnt_d = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      res_q   <= 1'b0;
      tk_q    <= 1'b0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      tk_q    <= tk_d;
      tgt_q   <= tgt_d;
    end
  end

  assign in_ready       = (state_q == IDLE);
  assign redirect_valid = (state_q == REDIRECT);
  assign flush          = (state_q == FLUSH);
  assign resolved       = res_q;
  assign taken          = tk_q;
  assign redirect_pc    = tgt_q;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] stat_taken_q;
  logic [STAT_W-1:0] stat_not_taken_q;

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_taken_q     <= '0;
      stat_not_taken_q <= '0;
    end else if (res_q) begin
      if (tk_q && !(&stat_taken_q))
        stat_taken_q <= stat_taken_q + 1'b1;
      if (!tk_q && !(&stat_not_taken_q))
        stat_not_taken_q <= stat_not_taken_q + 1'b1;
    end
  end

  assign stat_taken     = stat_taken_q;
  assign stat_not_taken = stat_not_taken_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with a cycle-level reference model.
// Build with BRANCH_STATS_EN to also exercise the counters.
module tb_branch_resolve;

  localparam int PC_W = 8;
  localparam int FC   = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      cond = 3'd0;
  logic            eq = 1'b0, neq = 1'b0, lt = 1'b0;
  logic            lte = 1'b0, gt = 1'b0, gte = 1'b0;
  logic [PC_W-1:0] pc = '0;
  logic [PC_W-1:0] offset = '0;
  logic            resolved;
  logic            taken;
  logic            redirect_valid;
  logic            redirect_ready = 1'b0;
  logic [PC_W-1:0] redirect_pc;
  logic            flush;
`ifdef BRANCH_STATS_EN
  logic [15:0]     stat_taken;
  logic [15:0]     stat_not_taken;
  logic [15:0]     m_st = '0;
  logic [15:0]     m_snt = '0;
  logic            sat_req = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  branch_resolve #(.PC_W(PC_W), .FLUSH_CYCLES(FC)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .cond           (cond),
    .eq             (eq),
    .neq            (neq),
    .lt             (lt),
    .lte            (lte),
    .gt             (gt),
    .gte            (gte),
    .pc             (pc),
    .offset         (offset),
    .resolved       (resolved),
    .taken          (taken),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .flush          (flush)
`ifdef BRANCH_STATS_EN
    ,
    .stat_taken     (stat_taken),
    .stat_not_taken (stat_not_taken)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: outstanding redirect plus remaining flush cycles.
  logic            m_res = 1'b0;
  logic            m_tk = 1'b0;
  logic            m_rv = 1'b0;
  logic [PC_W-1:0] m_tgt = '0;
  int              m_fl = 0;
  logic            m_ready;

  assign m_ready = !m_rv && (m_fl == 0);

  function automatic logic mtake(input logic [2:0] c,
                                 input logic [5:0] f);
    logic [7:0] tbl;
    tbl = {1'b1, f, 1'b0};
    return tbl[c];
  endfunction

  always @(posedge clk) begin
    logic acc;
    if (rst) begin
      m_res = 1'b0;
      m_tk  = 1'b0;
      m_rv  = 1'b0;
      m_fl  = 0;
`ifdef BRANCH_STATS_EN
      m_st  = '0;
      m_snt = '0;
`endif
    end else begin
`ifdef BRANCH_STATS_EN
      if (m_res && m_tk && m_st != 16'hFFFF) m_st = m_st + 1;
      if (m_res && !m_tk && m_snt != 16'hFFFF) m_snt = m_snt + 1;
      if (sat_req) m_st = 16'hFFFF;
`endif
      acc   = in_valid && m_ready;
      m_res = acc;
      m_tk  = acc && mtake(cond, {gte, gt, lte, lt, neq, eq});
      if (m_tk) begin
        m_rv  = 1'b1;
        m_tgt = PC_W'(pc + offset);
      end else if (m_rv && redirect_ready) begin
        m_rv = 1'b0;
        m_fl = FC;
      end else if (m_fl > 0) begin
        m_fl = m_fl - 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_in_ready", 32'(in_ready), 32'(m_ready));
      chk("m_resolved", 32'(resolved), 32'(m_res));
      if (m_res) chk("m_taken", 32'(taken), 32'(m_tk));
      chk("m_redirect_valid", 32'(redirect_valid), 32'(m_rv));
      if (m_rv) chk("m_redirect_pc", 32'(redirect_pc), 32'(m_tgt));
      chk("m_flush", 32'(flush), 32'(m_fl > 0));
`ifdef BRANCH_STATS_EN
      chk("m_stat_taken", 32'(stat_taken), 32'(m_st));
      chk("m_stat_not_taken", 32'(stat_not_taken), 32'(m_snt));
`endif
    end
  end

  // flags order: {gte, gt, lte, lt, neq, eq}
  task automatic drive(input logic [2:0] c, input logic [5:0] f,
                       input logic [7:0] p, input logic [7:0] o);
    in_valid = 1'b1;
    cond     = c;
    {gte, gt, lte, lt, neq, eq} = f;
    pc       = p;
    offset   = o;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!m_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!m_ready) begin
      checks++;
      failures++;
      $display("FAIL %s timeout actual=busy required=ready", nm);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_resolved", 32'(resolved), 32'd0);
    chk("rst_rv", 32'(redirect_valid), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);

    // EQ taken, 0x10 + 0x06
    rst = 1'b0;
    redirect_ready = 1'b1;
    drive(3'd1, 6'b000001, 8'h10, 8'h06);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t1_resolved", 32'(resolved), 32'd1);
    chk("t1_taken", 32'(taken), 32'd1);
    chk("t1_rv", 32'(redirect_valid), 32'd1);
    chk("t1_rpc", 32'(redirect_pc), 32'h16);
    chk("t1_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("t1_flush1", 32'(flush), 32'd1);
    @(negedge clk);
    chk("t1_flush2", 32'(flush), 32'd1);
    @(negedge clk);
    chk("t1_flush_end", 32'(flush), 32'd0);
    chk("t1_ready_back", 32'(in_ready), 32'd1);

    // LT not taken, then LE taken back-to-back
    drive(3'd3, 6'b000000, 8'h40, 8'h10);
    @(negedge clk);
    chk("t2a_resolved", 32'(resolved), 32'd1);
    chk("t2a_taken", 32'(taken), 32'd0);
    chk("t2a_rv", 32'(redirect_valid), 32'd0);
    chk("t2a_in_ready", 32'(in_ready), 32'd1);
    drive(3'd4, 6'b001000, 8'h20, 8'hFC);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t2b_resolved", 32'(resolved), 32'd1);
    chk("t2b_taken", 32'(taken), 32'd1);
    chk("t2b_rpc", 32'(redirect_pc), 32'h1C);
    wait_ready("t2_wait");

    // Redirect stalled by fetch for 5 cycles
    redirect_ready = 1'b0;
    drive(3'd7, 6'b000000, 8'h30, 8'h05);
    @(negedge clk);
    drive(3'd0, 6'b000000, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) begin
      chk("t3_rv_hold", 32'(redirect_valid), 32'd1);
      chk("t3_rpc_hold", 32'(redirect_pc), 32'h35);
      chk("t3_in_ready", 32'(in_ready), 32'd0);
      chk("t3_no_flush", 32'(flush), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    redirect_ready = 1'b1;
    @(negedge clk);
    chk("t3_flush_start", 32'(flush), 32'd1);
    chk("t3_rv_drop", 32'(redirect_valid), 32'd0);
    wait_ready("t3_wait");

    // Target wrap and NONE with every flag set
    drive(3'd7, 6'b000000, 8'hFE, 8'h04);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t4_wrap_rpc", 32'(redirect_pc), 32'h02);
    wait_ready("t4_wait");
    drive(3'd0, 6'b111111, 8'h70, 8'h01);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t4_none_resolved", 32'(resolved), 32'd1);
    chk("t4_none_taken", 32'(taken), 32'd0);
    chk("t4_none_rv", 32'(redirect_valid), 32'd0);

    // Reset during first flush cycle
    drive(3'd6, 6'b100000, 8'h80, 8'h10);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t5_rpc", 32'(redirect_pc), 32'h90);
    @(negedge clk);
    chk("t5_flush1", 32'(flush), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_flush_clr", 32'(flush), 32'd0);
    chk("t5_rv_clr", 32'(redirect_valid), 32'd0);
    chk("t5_ready", 32'(in_ready), 32'd1);
    drive(3'd2, 6'b000010, 8'h50, 8'h08);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t5_new_resolved", 32'(resolved), 32'd1);
    chk("t5_new_taken", 32'(taken), 32'd1);
    chk("t5_new_rpc", 32'(redirect_pc), 32'h58);
    wait_ready("t5_wait");

`ifdef BRANCH_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) drive(3'd7, 6'b000000, 8'(i), 8'h01);
      else drive(3'd0, 6'b000000, 8'(i), 8'h01);
      @(negedge clk);
      in_valid = 1'b0;
      wait_ready("st_wait");
    end
    repeat (2) @(negedge clk);
    chk("st_taken3", 32'(stat_taken), 32'd3);
    chk("st_not_taken2", 32'(stat_not_taken), 32'd2);
    force dut.stat_taken_q = 16'hFFFF;
    sat_req = 1'b1;
    @(negedge clk);
    release dut.stat_taken_q;
    sat_req = 1'b0;
    drive(3'd7, 6'b000000, 8'h11, 8'h01);
    @(negedge clk);
    in_valid = 1'b0;
    wait_ready("st_sat_wait");
    @(negedge clk);
    chk("st_sat", 32'(stat_taken), 32'hFFFF);
    chk("st_nt_keep", 32'(stat_not_taken), 32'd2);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
